// File: rtl/lsu_ctrl_if.sv
// Bundle for the LSU: request/response handshake plus the memory strobe bus.
// slave  = the LSU itself; master = requester that also provides memory read data.
interface lsu_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_func3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [2:0]        mem_func3;
   logic [31:0]       mem_rdata;

   modport master (
      output req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_read, mem_write, mem_addr, mem_wdata, mem_func3
   );

   modport slave (
      input  req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_read, mem_write, mem_addr, mem_wdata, mem_func3
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request, validates it, issues a
// single-cycle memory strobe and holds the response until consumed.
// Optional macro LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses are rejected with rsp_err instead of being passed to memory.
module lsu_ctrl #(
   parameter int ADDR_W    = 8,
   parameter int MEM_BYTES = 256
) (
   input logic       clk,
   input logic       rst_n,
   lsu_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_reg, state_next;
   logic              we_reg;
   logic [2:0]        func3_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [31:0]       wdata_reg;
   logic [31:0]       rdata_reg;
   logic              err_reg;

   logic              accept;
   logic              req_err;
   logic              func3_bad;
   logic              range_bad;
   logic              align_bad;
   logic [31:0]       size;
   logic [31:0]       end_addr;
   logic              req_ready;
   logic              rsp_valid;
   logic              mem_read;
   logic              mem_write;

   assign accept = bus.req_valid && (state_reg == IDLE);

   // Request validation: legal width code, in-range footprint, optional alignment.
   always_comb begin
      case (bus.req_func3[1:0])
         2'b01:   size = 32'd2;
         2'b10:   size = 32'd4;
         default: size = 32'd1;
      endcase
      // Full 32-bit sum so an access running off the top never wraps to a legal address.
      end_addr  = 32'(bus.req_addr) + size;
      range_bad = end_addr > 32'(MEM_BYTES);
      if (bus.req_we)
         func3_bad = bus.req_func3 > 3'b010;
      else
         func3_bad = (bus.req_func3 == 3'b011) || (bus.req_func3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
      align_bad = ((bus.req_func3[1:0] == 2'b01) && bus.req_addr[0]) ||
                  ((bus.req_func3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
      align_bad = 1'b0;
`endif
      req_err = func3_bad || range_bad || align_bad;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // FSM next state and handshake/strobe outputs.
   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (accept)
               state_next = req_err ? RESP : ACCESS;
         end
         ACCESS: begin
            mem_read   = !we_reg;
            mem_write  = we_reg;
            state_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (bus.rsp_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request capture on accept, load data capture at the end of ACCESS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_reg    <= 1'b0;
         func3_reg <= 3'b000;
         addr_reg  <= '0;
         wdata_reg <= 32'd0;
         rdata_reg <= 32'd0;
         err_reg   <= 1'b0;
      end else if (accept) begin
         we_reg    <= bus.req_we;
         func3_reg <= bus.req_func3;
         addr_reg  <= bus.req_addr;
         wdata_reg <= bus.req_wdata;
         rdata_reg <= 32'd0;
         err_reg   <= req_err;
      end else if (state_reg == ACCESS) begin
         rdata_reg <= we_reg ? 32'd0 : bus.mem_rdata;
      end else if ((state_reg == RESP) && bus.rsp_ready) begin
         rdata_reg <= 32'd0;
         err_reg   <= 1'b0;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_rdata = rdata_reg;
   assign bus.rsp_err   = err_reg;
   assign bus.mem_read  = mem_read;
   assign bus.mem_write = mem_write;
   // Memory fields are only driven during the strobe cycle.
   assign bus.mem_addr  = (state_reg == ACCESS) ? addr_reg  : '0;
   assign bus.mem_wdata = (state_reg == ACCESS) ? wdata_reg : 32'd0;
   assign bus.mem_func3 = (state_reg == ACCESS) ? func3_reg : 3'b000;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed corner cases followed by random
// requests, each checked against a rule-level reference model.
module tb_lsu_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   txn_no = 0;

   lsu_ctrl_if #(.ADDR_W(8)) bus ();

   lsu_ctrl #(.ADDR_W(8), .MEM_BYTES(256)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: is this request rejected?
   function automatic bit ref_err(input bit we, input bit [2:0] f3, input int addr);
      int sz;
      bit legal;
      legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      case (f3)
         3'd1, 3'd5: sz = 2;
         3'd2:       sz = 4;
         default:    sz = 1;
      endcase
      if (!legal) return 1'b1;
      if (addr + sz > 256) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
      if ((addr % sz) != 0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   task automatic run_txn(input bit we, input bit [2:0] f3, input int addr,
                          input logic [31:0] wd, input logic [31:0] md, input int stall);
      bit          exp_err;
      int          lat, rd_n, wr_n, busy_bad, quiet_bad, unstable;
      logic [31:0] s_addr, s_wd, s_f3, exp_rdata, held_rdata;
      logic        held_err;
      exp_err   = ref_err(we, f3, addr);
      exp_rdata = (exp_err || we) ? 32'd0 : md;
      lat = 0; rd_n = 0; wr_n = 0; busy_bad = 0; quiet_bad = 0; unstable = 0;
      s_addr = 0; s_wd = 0; s_f3 = 0;

      @(negedge clk);
      check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_func3 = f3;
      bus.req_addr  = addr[7:0];
      bus.req_wdata = wd;
      bus.mem_rdata = md;
      @(posedge clk);
      #1;
      // Scramble request fields so the response must come from captured values.
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom);
      bus.req_func3 = 3'($urandom);
      bus.req_addr  = 8'($urandom);
      bus.req_wdata = $urandom;

      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (bus.req_ready) busy_bad++;
         if (bus.mem_read) begin
            rd_n++;
            s_addr = 32'(bus.mem_addr); s_wd = bus.mem_wdata; s_f3 = 32'(bus.mem_func3);
         end
         if (bus.mem_write) begin
            wr_n++;
            s_addr = 32'(bus.mem_addr); s_wd = bus.mem_wdata; s_f3 = 32'(bus.mem_func3);
         end
         if (!bus.mem_read && !bus.mem_write &&
             (bus.mem_addr != 0 || bus.mem_wdata != 0 || bus.mem_func3 != 0))
            quiet_bad++;
         if (bus.rsp_valid) begin
            lat = n;
            break;
         end
      end

      check("rsp_latency", lat, exp_err ? 32'd1 : 32'd2);
      check("read_pulses", rd_n, (!we && !exp_err) ? 32'd1 : 32'd0);
      check("write_pulses", wr_n, (we && !exp_err) ? 32'd1 : 32'd0);
      if (!exp_err) begin
         check("mem_addr", s_addr, 32'(addr));
         check("mem_func3", s_f3, 32'(f3));
         check("mem_wdata", s_wd, wd);
      end
      check("bus_quiet", quiet_bad, 32'd0);
      check("req_ready_busy", busy_bad, 32'd0);
      check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
      check("rsp_rdata", bus.rsp_rdata, exp_rdata);

      held_rdata = bus.rsp_rdata;
      held_err   = bus.rsp_err;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (!bus.rsp_valid || bus.req_ready || bus.rsp_rdata !== held_rdata ||
             bus.rsp_err !== held_err)
            unstable++;
      end
      if (stall > 0) check("rsp_hold", unstable, 32'd0);

      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      check("back_to_idle", {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);

      txn_no++;
      $display("txn %0d we=%0d f3=%0d addr=%0d err=%0d rdata=%h stall=%0d",
               txn_no, we, f3, addr, exp_err, exp_rdata, stall);
   endtask

   initial begin
      int quiet;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_func3 = 3'd0;
      bus.req_addr  = 8'd0;
      bus.req_wdata = 32'd0;
      bus.rsp_ready = 1'b0;
      bus.mem_rdata = 32'd0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
      check("rst_rdata", bus.rsp_rdata, 32'd0);
      check("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

      // Directed cases.
      run_txn(1'b0, 3'b010, 200, 32'h0, 32'h0000_0011, 0);
      run_txn(1'b1, 3'b010, 212, 32'hDEAD_BEEF, 32'h1234_5678, 0);
      run_txn(1'b0, 3'b010, 254, 32'h0, 32'h5555_5555, 0);
      run_txn(1'b0, 3'b001, 201, 32'h0, 32'h0000_ABCD, 0);
      run_txn(1'b0, 3'b000, 255, 32'h0, 32'h0000_00FF, 5);
      run_txn(1'b1, 3'b100, 16, 32'hCAFE_F00D, 32'h0, 2);
      run_txn(1'b0, 3'b111, 16, 32'h0, 32'h0, 1);
      run_txn(1'b0, 3'b010, 252, 32'h0, 32'hA5A5_A5A5, 0);

      // Reset in the middle of ACCESS.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_func3 = 3'b010;
      bus.req_addr  = 8'd100;
      bus.mem_rdata = 32'h7777_7777;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_strobe", {31'd0, bus.mem_read}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_drop", {29'd0, bus.mem_read, bus.mem_write, bus.rsp_valid}, 32'd0);
      check("rst_async_ready", {31'd0, bus.req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.mem_read || bus.mem_write || bus.rsp_valid || !bus.req_ready) quiet++;
      end
      check("rst_no_replay", quiet, 32'd0);

      // Random requests, biased toward the top of memory.
      for (int t = 0; t < 200; t++) begin
         int a;
         a = ($urandom_range(0, 1) == 1) ? $urandom_range(248, 255) : $urandom_range(0, 255);
         run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                 $urandom, $urandom, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
